adder_share_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one instance of the team's 32-bit ripple-carry adder (`Adder32bit`) among `N_REQ` requesters. It accepts one add request at a time over a valid/ready handshake and registers the operands so the ripple chain gets a full clock cycle. It returns sum and carry-out with the requester ID over a second valid/ready handshake. It sits between the client blocks and the single shared adder; no client instantiates its own adder.

---
 rtl/adder_share_arbiter.sv | 92 +++++++++
 tb/tb_adder_share_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter: round-robin sharing of one Adder32bit among N_REQ requesters (req_valid/req_ready/req_a/req_b/req_cin in, rsp_valid/rsp_ready/rsp_sum/rsp_cout/rsp_id out, busy)
module adder_share_arbiter #(
  parameter int N_REQ = 4,
  localparam int ID_W = $clog2(N_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [32*N_REQ-1:0]   req_a,
  input  logic [32*N_REQ-1:0]   req_b,
  input  logic [N_REQ-1:0]      req_cin,
  output logic [N_REQ-1:0]      req_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_sum,
  output logic                  rsp_cout,
  output logic [ID_W-1:0]       rsp_id,
  output logic                  busy
);
  typedef enum logic [1:0] {IDLE, ADD, HOLD} state_t;
  state_t state;
  logic [ID_W-1:0] ptr, id_r, g, idx;
  logic [31:0] a_r, b_r, s, sel_a, sel_b;
  logic cin_r, cout, any;
  always_comb begin
    g = ptr;
    idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = ID_W'((int'(ptr) + k) % N_REQ);
      g = req_valid[idx] ? idx : g;
    end
  end
  assign any = |req_valid;
  assign sel_a = 32'(req_a >> {g, 5'd0});
  assign sel_b = 32'(req_b >> {g, 5'd0});
  assign req_ready = (state == IDLE && !rst && any) ? N_REQ'(1) << g : '0;
  assign busy = state != IDLE;
  Adder32bit u_add (.a(a_r), .b(b_r), .cin(cin_r), .s(s), .cout(cout));
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      id_r <= '0;
      a_r <= '0;
      b_r <= '0;
      cin_r <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_sum <= '0;
      rsp_cout <= 1'b0;
      rsp_id <= '0;
    end else begin
      case (state)
        IDLE: if (any) begin
          a_r <= sel_a;
          b_r <= sel_b;
          cin_r <= req_cin[g];
          id_r <= g;
          ptr <= (g == ID_W'(N_REQ - 1)) ? '0 : g + 1'b1;
          state <= ADD;
        end
        ADD: begin
          rsp_sum <= s;
          rsp_cout <= cout;
          rsp_id <= id_r;
          rsp_valid <= 1'b1;
          state <= HOLD;
        end
        HOLD: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

module Adder32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] s,
  output logic        cout
);
  logic [32:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < 32; i++) begin : g_fa
    assign s[i] = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign cout = c[32];
endmodule

// File: tb/tb_adder_share_arbiter.sv
// tb_adder_share_arbiter: directed self-checking bench for adder_share_arbiter
module tb_adder_share_arbiter;
  localparam int N = 4;
  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] req_valid, req_cin, req_ready;
  logic [32*N-1:0] req_a, req_b;
  logic rsp_valid, rsp_ready, rsp_cout, busy;
  logic [31:0] rsp_sum;
  logic [1:0] rsp_id;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  adder_share_arbiter #(.N_REQ(N)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_cin(req_cin), .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_id(rsp_id), .busy(busy)
  );
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic mid;
    @(negedge clk);
  endtask
  task automatic test_reset;
    rst = 1'b1;
    req_valid = '1;
    req_a = '0;
    req_b = '0;
    req_cin = '0;
    rsp_ready = 1'b1;
    cyc;
    cyc;
    mid;
    n_chk++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    n_chk++; if ({rsp_valid, busy, rsp_cout} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got valid/busy/cout %b want 000", {rsp_valid, busy, rsp_cout}); end
    n_chk++; if (rsp_sum !== 32'h0 || rsp_id !== 2'd0) begin n_fail++; $display("FAIL reset_rsp: got sum %h id %0d want 0 0", rsp_sum, rsp_id); end
    cyc;
    rst = 1'b0;
    req_valid = '0;
    mid;
    n_chk++; if (busy !== 1'b0 || req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_idle: got busy %b ready %b want 0 0000", busy, req_ready); end
    cyc;
  endtask
  task automatic single_add(input int idx, input logic [31:0] a, input logic [31:0] b, input logic cin,
                            input logic [31:0] es, input logic ec, input string tag);
    req_a[32*idx +: 32] = a;
    req_b[32*idx +: 32] = b;
    req_cin[idx] = cin;
    req_valid[idx] = 1'b1;
    mid;
    n_chk++; if (req_ready !== 4'(1 << idx)) begin n_fail++; $display("FAIL %s_grant: got %b want %b", tag, req_ready, 4'(1 << idx)); end
    cyc;
    req_valid[idx] = 1'b0;
    mid;
    n_chk++; if ({rsp_valid, busy, req_ready} !== 6'b010000) begin n_fail++; $display("FAIL %s_add: got valid/busy/ready %b want 010000", tag, {rsp_valid, busy, req_ready}); end
    cyc;
    mid;
    n_chk++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL %s_valid: got %b want 1", tag, rsp_valid); end
    n_chk++; if ({rsp_cout, rsp_sum} !== {ec, es}) begin n_fail++; $display("FAIL %s_sum: got %b_%h want %b_%h", tag, rsp_cout, rsp_sum, ec, es); end
    n_chk++; if (rsp_id !== 2'(idx)) begin n_fail++; $display("FAIL %s_id: got %0d want %0d", tag, rsp_id, idx); end
    cyc;
    mid;
    n_chk++; if ({rsp_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL %s_done: got valid/busy %b want 00", tag, {rsp_valid, busy}); end
    cyc;
  endtask
  task automatic test_single;
    single_add(0, 32'h00000005, 32'h00000003, 1'b0, 32'h00000008, 1'b0, "single");
  endtask
  task automatic test_carry;
    single_add(2, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, "wrap");
    single_add(2, 32'h7FFFFFFF, 32'h00000001, 1'b1, 32'h80000001, 1'b0, "cin");
    single_add(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, "max");
  endtask
  task automatic test_round_robin;
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      req_a[32*i +: 32] = 32'(i * 16);
      req_b[32*i +: 32] = 32'h1;
    end
    req_cin = '0;
    req_valid = '1;
    rsp_ready = 1'b1;
    cyc;
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      mid;
      n_chk++; if (req_ready !== 4'(1 << i)) begin n_fail++; $display("FAIL rr_grant%0d: got %b want %b", i, req_ready, 4'(1 << i)); end
      cyc;
      req_valid[i] = 1'b0;
      cyc;
      mid;
      n_chk++; if (rsp_id !== 2'(i) || rsp_sum !== 32'(i * 16 + 1)) begin n_fail++; $display("FAIL rr_rsp%0d: got id %0d sum %h want %0d %h", i, rsp_id, rsp_sum, i, 32'(i * 16 + 1)); end
      cyc;
    end
    req_valid = 4'b1001;
    mid;
    n_chk++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL rr_0before3: got %b want 0001", req_ready); end
    cyc;
    req_valid[0] = 1'b0;
    cyc;
    cyc;
    mid;
    n_chk++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL rr_then3: got %b want 1000", req_ready); end
    cyc;
    req_valid[3] = 1'b0;
    cyc;
    cyc;
  endtask
  task automatic test_wrap_fairness;
    req_valid = 4'b0010;
    mid;
    n_chk++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL fair_g1: got %b want 0010", req_ready); end
    cyc;
    req_valid = 4'b1001;
    cyc;
    cyc;
    mid;
    n_chk++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL fair_3first: got %b want 1000", req_ready); end
    cyc;
    req_valid[3] = 1'b0;
    cyc;
    cyc;
    mid;
    n_chk++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL fair_0next: got %b want 0001", req_ready); end
    cyc;
    req_valid[0] = 1'b0;
    cyc;
    cyc;
  endtask
  task automatic test_backpressure;
    int bad;
    rsp_ready = 1'b0;
    req_a[31:0] = 32'h12345678;
    req_b[31:0] = 32'h11111111;
    req_cin[0] = 1'b1;
    req_a[63:32] = 32'hA0000000;
    req_b[63:32] = 32'h60000000;
    req_cin[1] = 1'b0;
    req_valid = 4'b0001;
    mid;
    n_chk++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL bp_grant0: got %b want 0001", req_ready); end
    cyc;
    req_valid = 4'b0010;
    mid;
    n_chk++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_add_ready: got %b want 0000", req_ready); end
    cyc;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      mid;
      if ({rsp_valid, busy, req_ready, rsp_cout, rsp_id, rsp_sum} !== {1'b1, 1'b1, 4'b0000, 1'b0, 2'd0, 32'h2345678A}) bad++;
      cyc;
    end
    n_chk++; if (bad !== 0) begin n_fail++; $display("FAIL bp_hold: got %0d unstable cycles want 0", bad); end
    rsp_ready = 1'b1;
    mid;
    n_chk++; if (rsp_valid !== 1'b1 || req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_handshake: got valid %b ready %b want 1 0000", rsp_valid, req_ready); end
    cyc;
    mid;
    n_chk++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_grant1: got %b want 0010", req_ready); end
    n_chk++; if ({rsp_valid, busy} !== 2'b00 || rsp_sum !== 32'h2345678A) begin n_fail++; $display("FAIL bp_keep: got valid/busy %b sum %h want 00 2345678a", {rsp_valid, busy}, rsp_sum); end
    cyc;
    req_valid = '0;
    cyc;
    mid;
    n_chk++; if ({rsp_cout, rsp_sum, rsp_id} !== {1'b1, 32'h0, 2'd1}) begin n_fail++; $display("FAIL bp_rsp1: got cout %b sum %h id %0d want 1 0 1", rsp_cout, rsp_sum, rsp_id); end
    cyc;
  endtask
  task automatic test_reset_mid;
    int bad;
    req_a[95:64] = 32'h1;
    req_b[95:64] = 32'h2;
    req_valid = 4'b0100;
    mid;
    n_chk++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL rm_grant: got %b want 0100", req_ready); end
    cyc;
    rst = 1'b1;
    req_valid = '0;
    mid;
    n_chk++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL rm_ready: got %b want 0000", req_ready); end
    cyc;
    rst = 1'b0;
    mid;
    n_chk++; if ({rsp_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL rm_flush: got valid/busy %b want 00", {rsp_valid, busy}); end
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      cyc;
      mid;
      if (rsp_valid !== 1'b0) bad++;
    end
    n_chk++; if (bad !== 0) begin n_fail++; $display("FAIL rm_no_rsp: got %0d valid cycles want 0", bad); end
    cyc;
    req_valid = 4'b1010;
    mid;
    n_chk++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL rm_ptr0: got %b want 0010", req_ready); end
    cyc;
    req_valid = '0;
    cyc;
    cyc;
  endtask
  initial begin
    test_reset;
    test_single;
    test_carry;
    test_round_robin;
    test_wrap_fairness;
    test_backpressure;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
